sevenseg_scan_decoder: RTL and testbench



---
 rtl/sevenseg_scan_decoder.sv | 198 +++++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - reconstructs hex digits from a scanned, active-low 7-segment display
//
// Samples the multiplexed anode/segment/dp lines of a scanned display and
// rebuilds the hex nibble, decimal point and glyph-error flag for every
// digit. A complete frame is published atomically once every digit has
// been captured.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         asynchronous, active-high reset
//   an            anode selects, active-low, asynchronous to clk
//   seg           segment lines {g,f,e,d,c,b,a}, active-low, asynchronous
//   dp            decimal point, active-low, asynchronous
//   digits        decoded nibbles, digit i at [4i+3:4i]
//   dp_out        decimal point lit per digit (1 = lit)
//   digit_err     1 = captured pattern is not a hex glyph
//   frame_valid   one-cycle pulse when digits/dp_out/digit_err update
//   frame_timeout one-cycle pulse when a partial frame is discarded
module sevenseg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 2_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic [6:0]                seg,
    input  logic                      dp,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_valid,
    output logic                      frame_timeout
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_e;

    // Synchronizer and previous-sample register; all-ones means a dark display.
    logic [SW-1:0]           s1, s2, prev;
    logic [7:0]              cnt;
    logic [31:0]             timer;
    state_e                  state, state_n;
    logic [NUM_DIGITS-1:0]   seen, seen_n, cap_mask, seen_cap;
    logic [4*NUM_DIGITS-1:0] sh_nib, sh_nib_n;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_n, sh_err, sh_err_n;

    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic                    dp_s;
    logic                    stable, capture, one_low, timeout_now;
    logic [IW-1:0]           idx;
    int                      nlow;
    logic [3:0]              dec_nib;
    logic                    dec_err;

    assign an_s   = s2[SW-1 -: NUM_DIGITS];
    assign seg_s  = s2[7:1];
    assign dp_s   = s2[0];
    assign stable = (s2 == prev);

    // Capture only on the cycle the counter would first saturate, so one
    // stable dwell produces at most one capture.
    assign capture = stable && (cnt == 8'(SETTLE_CYCLES - 1)) && one_low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '1;
            s2   <= '1;
            prev <= '1;
            cnt  <= '0;
        end else begin
            s1   <= {an, seg, dp};
            s2   <= s1;
            prev <= s2;
            if (!stable)
                cnt <= '0;
            else if (cnt != 8'(SETTLE_CYCLES))
                cnt <= cnt + 8'd1;
        end
    end

    // Exactly-one-anode-low detection and its index.
    always_comb begin
        nlow = 0;
        idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                nlow = nlow + 1;
                idx  = IW'(i);
            end
        end
        one_low = (nlow == 1);
    end

    always_comb begin
        dec_err = 1'b0;
        dec_nib = 4'h0;
        case (seg_s)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h18: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    assign cap_mask = capture ? (NUM_DIGITS'(1) << idx) : '0;
    assign seen_cap = seen | cap_mask;

    // Next-state, shadow and seen. Leaving a frame (publish or timeout)
    // restarts seen from the current capture so a digit landing in that
    // cycle belongs to the next frame.
    always_comb begin
        state_n     = state;
        seen_n      = seen;
        sh_nib_n    = sh_nib;
        sh_dp_n     = sh_dp;
        sh_err_n    = sh_err;
        timeout_now = 1'b0;

        if (capture) begin
            sh_nib_n[4*idx +: 4] = dec_nib;
            sh_dp_n[idx]         = ~dp_s;
            sh_err_n[idx]        = dec_err;
        end

        case (state)
            COLLECT: begin
                if (&seen_cap) begin
                    state_n = PUBLISH;
                    seen_n  = seen_cap;
                end else if (timer == 32'(FRAME_TIMEOUT - 1)) begin
                    timeout_now = 1'b1;
                    seen_n      = cap_mask;
                    state_n     = capture ? COLLECT : IDLE;
                end else begin
                    seen_n = seen_cap;
                end
            end
            default: begin
                seen_n = cap_mask;
                if (!capture)
                    state_n = IDLE;
                else if (&cap_mask)
                    state_n = PUBLISH;
                else
                    state_n = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            seen          <= '0;
            timer         <= '0;
            sh_nib        <= '0;
            sh_dp         <= '0;
            sh_err        <= '0;
            digits        <= '0;
            dp_out        <= '0;
            digit_err     <= '0;
            frame_valid   <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            seen          <= seen_n;
            sh_nib        <= sh_nib_n;
            sh_dp         <= sh_dp_n;
            sh_err        <= sh_err_n;
            timer         <= (state == COLLECT && state_n == COLLECT) ? timer + 32'd1 : 32'd0;
            frame_valid   <= (state_n == PUBLISH);
            frame_timeout <= timeout_now;
            // Outputs load on entry to PUBLISH so they are valid with frame_valid.
            if (state_n == PUBLISH) begin
                digits    <= sh_nib_n;
                dp_out    <= sh_dp_n;
                digit_err <= sh_err_n;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - scoreboard bench for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

    localparam int N  = 8;
    localparam int SC = 4;
    localparam int FT = 2000;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp_out, digit_err;
    logic           frame_valid, frame_timeout;

    sevenseg_scan_decoder #(.NUM_DIGITS(N), .SETTLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .dp(dp),
        .digits(digits), .dp_out(dp_out), .digit_err(digit_err),
        .frame_valid(frame_valid), .frame_timeout(frame_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*N-1:0] d;
        logic [N-1:0]   p;
        logic [N-1:0]   e;
    } frame_t;

    frame_t q[$];
    frame_t last_exp;
    int vectors = 0;
    int miscompares = 0;
    int n_frames = 0;
    int n_timeouts = 0;
    int cyc = 0;
    int t_timeout = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h18;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Returns {err, nibble} by searching the glyph table.
    function automatic logic [4:0] decode_ref(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (glyph(k) == s) return {1'b0, 4'(k)};
        return 5'b1_0000;
    endfunction

    function automatic frame_t model(input logic [7*N-1:0] segs, input logic [N-1:0] dpn);
        frame_t f;
        logic [4:0] r;
        for (int i = 0; i < N; i++) begin
            r = decode_ref(segs[7*i +: 7]);
            f.d[4*i +: 4] = r[3:0];
            f.e[i]        = r[4];
            f.p[i]        = ~dpn[i];
        end
        return f;
    endfunction

    // Scoreboard: compare each published frame against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid && frame_timeout) begin
                vectors++; miscompares++;
                $display("FAIL pulse_overlap: frame_valid=1 frame_timeout=1, required not both");
            end
            if (frame_timeout) begin
                n_timeouts++;
                t_timeout = cyc;
            end
            if (frame_valid) begin
                n_frames++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame: digits=%h, required no frame", digits);
                end else begin
                    frame_t f;
                    f = q.pop_front();
                    vectors += 2;
                    if (digits !== f.d) begin
                        miscompares++;
                        $display("FAIL frame_digits: got %h, required %h", digits, f.d);
                    end
                    if (dp_out !== f.p) begin
                        miscompares++;
                        $display("FAIL frame_dp: got %h, required %h", dp_out, f.p);
                    end
                    if (digit_err !== f.e) begin
                        miscompares++;
                        $display("FAIL frame_err: got %h, required %h", digit_err, f.e);
                    end
                end
            end
        end
    end

    task automatic disp(input logic [N-1:0] a, input logic [6:0] s, input logic d, input int n);
        #1;
        an = a; seg = s; dp = d;
        repeat (n) @(posedge clk);
    endtask

    task automatic scan(input logic [7*N-1:0] segs, input logic [N-1:0] dpn, input bit expect_frame);
        if (expect_frame) begin
            last_exp = model(segs, dpn);
            q.push_back(last_exp);
        end
        for (int i = 0; i < N; i++)
            disp(~(N'(1) << i), segs[7*i +: 7], dpn[i], 64);
        disp('1, 7'h7F, 1'b1, 16);
    endtask

    task automatic check_frames(input string name, input int f0, input int want);
        vectors += 2;
        if (n_frames - f0 !== want) begin
            miscompares++;
            $display("FAIL %s_count: got %0d frames, required %0d", name, n_frames - f0, want);
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending: %0d expected frames never published, required 0", name, q.size());
        end
    endtask

    function automatic logic [7*N-1:0] seq_segs(input int base);
        logic [7*N-1:0] s;
        for (int i = 0; i < N; i++) s[7*i +: 7] = glyph(base + i);
        return s;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        disp('1, 7'h7F, 1'b1, 3);
        #1;
        vectors += 5;
        if (digits !== '0)      begin miscompares++; $display("FAIL reset_digits: got %h, required 0", digits); end
        if (dp_out !== '0)      begin miscompares++; $display("FAIL reset_dp: got %h, required 0", dp_out); end
        if (digit_err !== '0)   begin miscompares++; $display("FAIL reset_err: got %h, required 0", digit_err); end
        if (frame_valid !== 0)  begin miscompares++; $display("FAIL reset_fv: got %b, required 0", frame_valid); end
        if (frame_timeout !== 0) begin miscompares++; $display("FAIL reset_to: got %b, required 0", frame_timeout); end
        reset = 1'b0;
        disp('1, 7'h7F, 1'b1, 10);
    endtask

    task automatic test_digits_0_7;
        int f0 = n_frames, t0 = n_timeouts;
        scan(seq_segs(0), '1, 1'b1);
        check_frames("scan07", f0, 1);
        vectors++;
        if (n_timeouts != t0) begin miscompares++; $display("FAIL scan07_timeout: got %0d, required 0", n_timeouts - t0); end
    endtask

    task automatic test_hex_8_f_dp;
        int f0 = n_frames;
        scan(seq_segs(8), 8'hF7, 1'b1);
        check_frames("scan8f", f0, 1);
    endtask

    task automatic test_err_glyphs;
        int f0 = n_frames;
        logic [7*N-1:0] s;
        s = seq_segs(0);
        s[7*5 +: 7] = 7'h3F;
        s[7*2 +: 7] = 7'h7F;
        scan(s, '1, 1'b1);
        check_frames("errglyph", f0, 1);
    endtask

    task automatic test_glitch_multi;
        int f0 = n_frames;
        logic [7*N-1:0] s;
        s = seq_segs(1);
        last_exp = model(s, 8'hFE);
        q.push_back(last_exp);
        for (int i = 0; i < N; i++) begin
            disp(~(N'(1) << i), s[7*i +: 7], (i == 0) ? 1'b0 : 1'b1, 64);
            // Two anodes low with a different glyph: must not touch digits 0/1.
            if (i == 1) disp(8'hFC, glyph(9), 1'b0, 64);
            // Short segment glitch on digit 4: must not overwrite it.
            if (i == 4) disp(8'hEF, glyph(14), 1'b1, SC - 1);
        end
        disp('1, 7'h7F, 1'b1, 16);
        check_frames("glitch", f0, 1);
    endtask

    task automatic test_timeout;
        int f0 = n_frames, t0 = n_timeouts, start;
        logic [7*N-1:0] s;
        s = seq_segs(3);
        start = cyc;
        for (int i = 0; i < N - 1; i++) disp(~(N'(1) << i), s[7*i +: 7], 1'b1, 64);
        disp('1, 7'h7F, 1'b1, 1700);
        vectors += 5;
        if (n_timeouts - t0 != 1) begin miscompares++; $display("FAIL timeout_count: got %0d, required 1", n_timeouts - t0); end
        if (t_timeout - start < FT || t_timeout - start > FT + 16) begin
            miscompares++; $display("FAIL timeout_time: got %0d cycles, required %0d..%0d", t_timeout - start, FT, FT + 16);
        end
        if (n_frames != f0) begin miscompares++; $display("FAIL timeout_frame: got %0d frames, required 0", n_frames - f0); end
        if (digits !== last_exp.d) begin miscompares++; $display("FAIL timeout_hold_digits: got %h, required %h", digits, last_exp.d); end
        if (dp_out !== last_exp.p) begin miscompares++; $display("FAIL timeout_hold_dp: got %h, required %h", dp_out, last_exp.p); end
        scan(seq_segs(5), 8'h7F, 1'b1);
        check_frames("after_timeout", f0, 1);
    endtask

    task automatic test_reset_midframe;
        int f0;
        logic [7*N-1:0] s;
        s = seq_segs(6);
        for (int i = 0; i < 4; i++) disp(~(N'(1) << i), s[7*i +: 7], 1'b0, 64);
        #2 reset = 1'b1;
        #1;
        vectors += 3;
        if (digits !== '0)    begin miscompares++; $display("FAIL midreset_digits: got %h, required 0", digits); end
        if (dp_out !== '0)    begin miscompares++; $display("FAIL midreset_dp: got %h, required 0", dp_out); end
        if (digit_err !== '0) begin miscompares++; $display("FAIL midreset_err: got %h, required 0", digit_err); end
        repeat (2) @(posedge clk);
        reset = 1'b0;
        disp('1, 7'h7F, 1'b1, 8);
        f0 = n_frames;
        scan(seq_segs(2), 8'hAA, 1'b1);
        check_frames("midreset", f0, 1);
    endtask

    initial begin
        reset = 1'b1;
        an = '1; seg = 7'h7F; dp = 1'b1;
        test_reset;
        test_digits_0_7;
        test_hex_8_f_dp;
        test_err_glyphs;
        test_glitch_multi;
        test_timeout;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
